// File: rtl/imem_boot_loader_if.sv
// Loader handshake bundle: byte stream in, instruction-memory write port and CPU control out.
// master = stream source / observer, slave = the loader itself.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_reset, busy, done, error, words_loaded
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata,
    output cpu_reset, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Packs a length-prefixed big-endian byte stream into imem words (strobe 1 cycle after 4th byte), holding the CPU in reset until loaded.
// rx_ready is registered per state; optional trailing XOR checksum byte under LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  imem_boot_loader_if.slave bus
);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_ERR
  } state_t;

  state_t            r_state;
  logic              r_rx_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [15:0]       r_words;
  logic [15:0]       r_len;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`else
  logic              r_fin;
`endif

  logic        w_acc;
  logic [16:0] w_len;
  logic        w_last_word;

  assign w_acc       = bus.rx_valid && r_rx_ready;
  assign w_len       = {1'b0, r_len[15:8], bus.rx_data};
  assign w_last_word = (r_words + 16'd1) == r_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
      r_len       <= '0;
      r_byte_cnt  <= '0;
      r_asm       <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_xor       <= '0;
`else
      r_fin       <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      // The word index advances at the edge that ends each strobe.
      if (r_we) r_addr <= r_addr + ADDR_W'(1);

      case (r_state)
        S_IDLE, S_RUN, S_ERR: begin
          if (bus.start) begin
            r_state     <= S_LEN_HI;
            r_rx_ready  <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_words     <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_byte_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_xor       <= '0;
`else
            r_fin       <= 1'b0;
`endif
          end
        end

        S_LEN_HI: begin
          if (w_acc) begin
            r_len[15:8] <= bus.rx_data;
            r_state     <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (w_acc) begin
            r_len[7:0] <= bus.rx_data;
            if (w_len > DEPTH) begin
              r_state    <= S_ERR;
              r_rx_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end else if (w_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state     <= S_CHK;
`else
              r_state     <= S_RUN;
              r_rx_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
`ifndef LOADER_CHECKSUM_EN
          // Release the CPU one edge after the final strobe so the write lands before the first fetch.
          if (r_fin) begin
            r_fin       <= 1'b0;
            r_state     <= S_RUN;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end else
`endif
          if (w_acc) begin
`ifdef LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ bus.rx_data;
`endif
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= {r_asm, bus.rx_data};
              r_words <= r_words + 16'd1;
              if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                r_state    <= S_CHK;
`else
                r_rx_ready <= 1'b0;
                r_fin      <= 1'b1;
`endif
              end
            end else begin
              r_asm <= {r_asm[15:0], bus.rx_data};
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_acc) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (bus.rx_data == r_xor) begin
              r_state     <= S_RUN;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready     = r_rx_ready;
  assign bus.imem_we      = r_we;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.cpu_reset    = r_cpu_reset;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.words_loaded = r_words;
endmodule
